// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the MEM-stage load/store unit: width encodings,
// FSM state encoding, bus byte-enable width and control legality helpers.
package load_store_unit_pkg;

    localparam logic [3:0] MEM_WIDTH_WORD = 4'b0000;
    localparam logic [3:0] MEM_WIDTH_HALF = 4'b0101;
    localparam logic [3:0] MEM_WIDTH_BYTE = 4'b1010;

    localparam int BE_W = 4;

    typedef enum logic [1:0] {
        LSU_IDLE = 2'b00,
        LSU_REQ  = 2'b01,
        LSU_DONE = 2'b10
    } lsu_state_t;

    function automatic logic width_is_legal(input logic [3:0] width);
        logic legal;
        case (width)
            MEM_WIDTH_WORD, MEM_WIDTH_HALF, MEM_WIDTH_BYTE: legal = 1'b1;
            default:                                        legal = 1'b0;
        endcase
        return legal;
    endfunction

    function automatic logic is_misaligned(input logic [3:0] width, input logic [1:0] addr_lo);
        logic mis;
        case (width)
            MEM_WIDTH_WORD: mis = (addr_lo != 2'b00);
            MEM_WIDTH_HALF: mis = addr_lo[0];
            default:        mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Single-outstanding req/ack data bus between the load/store unit (master)
// and the data memory / bus fabric (slave).
interface load_store_unit_if;
    import load_store_unit_pkg::*;

    logic            bus_req_out;
    logic            bus_we_out;
    logic [31:0]     bus_addr_out;
    logic [BE_W-1:0] bus_be_out;
    logic [31:0]     bus_wdata_out;
    logic            bus_ack_in;
    logic [31:0]     bus_rdata_in;

    modport master (
        output bus_req_out, bus_we_out, bus_addr_out, bus_be_out, bus_wdata_out,
        input  bus_ack_in, bus_rdata_in
    );

    modport slave (
        input  bus_req_out, bus_we_out, bus_addr_out, bus_be_out, bus_wdata_out,
        output bus_ack_in, bus_rdata_in
    );

endinterface

// File: rtl/load_store_unit_align.sv
// Combinational lane steering: byte enables and replicated store data for a
// sub-word access, plus load byte/half extraction with sign or zero extension.
module lsu_align
    import load_store_unit_pkg::*;
(
    input  logic [3:0]      width,
    input  logic [1:0]      addr_lo,
    input  logic            zero_extend,
    input  logic [31:0]     wdata,
    input  logic [31:0]     rdata,
    output logic [BE_W-1:0] be,
    output logic [31:0]     wdata_lane,
    output logic [31:0]     rdata_ext
);

    logic [31:0] byte_shift_s;
    logic [31:0] half_shift_s;

    // Lane select and extension per access width; unknown widths yield no lanes.
    always_comb begin
        be           = 4'b0000;
        wdata_lane   = wdata;
        rdata_ext    = 32'h0000_0000;
        byte_shift_s = rdata >> {addr_lo, 3'b000};
        half_shift_s = rdata >> {addr_lo[1], 4'b0000};
        case (width)
            MEM_WIDTH_BYTE: begin
                be         = 4'b0001 << addr_lo;
                wdata_lane = {4{wdata[7:0]}};
                if (zero_extend) begin
                    rdata_ext = {24'h00_0000, byte_shift_s[7:0]};
                end else begin
                    rdata_ext = {{24{byte_shift_s[7]}}, byte_shift_s[7:0]};
                end
            end
            MEM_WIDTH_HALF: begin
                be         = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata_lane = {2{wdata[15:0]}};
                if (zero_extend) begin
                    rdata_ext = {16'h0000, half_shift_s[15:0]};
                end else begin
                    rdata_ext = {{16{half_shift_s[15]}}, half_shift_s[15:0]};
                end
            end
            MEM_WIDTH_WORD: begin
                be         = 4'b1111;
                wdata_lane = wdata;
                rdata_ext  = rdata;
            end
            default: begin
                be         = 4'b0000;
                wdata_lane = wdata;
                rdata_ext  = 32'h0000_0000;
            end
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// MEM-stage load/store unit: accepts one memory micro-op, runs a single
// req/ack bus transaction (or rejects it as illegal/misaligned) and stalls until done.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
)
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        valid_in,
    input  logic        mem_read_in,
    input  logic        mem_write_in,
    input  logic [3:0]  mem_width_in,
    input  logic        mem_zero_extend_in,
    input  logic [31:0] addr_in,
    input  logic [31:0] wdata_in,
    output logic        busy_out,
    output logic        done_out,
    output logic [31:0] rdata_out,
    output logic        misaligned_out,
    output logic        fault_out,
    load_store_unit_if.master bus
);

    localparam logic [1:0] ST_IDLE = LSU_IDLE;
    localparam logic [1:0] ST_REQ  = LSU_REQ;
    localparam logic [1:0] ST_DONE = LSU_DONE;

    // Counter only needs to reach TIMEOUT_CYCLES-1: the last waiting cycle is the timeout cycle.
    localparam int               CNT_W        = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic             TIMEOUT_EN   = (TIMEOUT_CYCLES != 0);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1)
                                                                      : {CNT_W{1'b0}};

    logic [1:0]       state_r;
    logic [1:0]       next_state_s;
    logic [CNT_W-1:0] cnt_r;
    logic [3:0]       width_r;
    logic             zext_r;
    logic [1:0]       addr_lo_r;

    logic             busy_r;
    logic             done_r;
    logic [31:0]      rdata_r;
    logic             mis_r;
    logic             fault_r;
    logic             req_r;
    logic             we_r;
    logic [31:0]      baddr_r;
    logic [BE_W-1:0]  be_r;
    logic [31:0]      bwdata_r;

    logic             accept_s;
    logic             illegal_s;
    logic             misaligned_s;
    logic             timeout_s;

    logic [3:0]       align_width_s;
    logic [1:0]       align_addr_lo_s;
    logic             align_zext_s;
    logic [BE_W-1:0]  align_be_s;
    logic [31:0]      align_wdata_s;
    logic [31:0]      align_rdata_s;

    assign accept_s     = (state_r == ST_IDLE) && valid_in && (mem_read_in || mem_write_in);
    assign illegal_s    = (mem_read_in && mem_write_in) || !width_is_legal(mem_width_in);
    assign misaligned_s = is_misaligned(mem_width_in, addr_in[1:0]);
    assign timeout_s    = TIMEOUT_EN && (cnt_r == TIMEOUT_LAST);

    // The one aligner serves the live inputs at accept and the latched op while waiting for ack.
    always_comb begin
        if (state_r == ST_IDLE) begin
            align_width_s   = mem_width_in;
            align_addr_lo_s = addr_in[1:0];
            align_zext_s    = mem_zero_extend_in;
        end else begin
            align_width_s   = width_r;
            align_addr_lo_s = addr_lo_r;
            align_zext_s    = zext_r;
        end
    end

    lsu_align u_align (
        .width       (align_width_s),
        .addr_lo     (align_addr_lo_s),
        .zero_extend (align_zext_s),
        .wdata       (wdata_in),
        .rdata       (bus.bus_rdata_in),
        .be          (align_be_s),
        .wdata_lane  (align_wdata_s),
        .rdata_ext   (align_rdata_s)
    );

    // Next-state logic; ack takes precedence over the timeout.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    next_state_s = (illegal_s || misaligned_s) ? ST_DONE : ST_REQ;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (bus.bus_ack_in || timeout_s) begin
                    next_state_s = ST_DONE;
                end else begin
                    next_state_s = ST_REQ;
                end
            end
            ST_DONE: next_state_s = ST_IDLE;
            default: next_state_s = ST_IDLE;
        endcase
    end

    // State, timeout counter, latched op and all registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            cnt_r     <= {CNT_W{1'b0}};
            width_r   <= 4'b0000;
            zext_r    <= 1'b0;
            addr_lo_r <= 2'b00;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            rdata_r   <= 32'h0000_0000;
            mis_r     <= 1'b0;
            fault_r   <= 1'b0;
            req_r     <= 1'b0;
            we_r      <= 1'b0;
            baddr_r   <= 32'h0000_0000;
            be_r      <= 4'b0000;
            bwdata_r  <= 32'h0000_0000;
        end else begin
            state_r <= next_state_s;
            busy_r  <= (next_state_s != ST_IDLE);
            done_r  <= (next_state_s == ST_DONE);
            req_r   <= (next_state_s == ST_REQ);
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        width_r   <= mem_width_in;
                        zext_r    <= mem_zero_extend_in;
                        addr_lo_r <= addr_in[1:0];
                        cnt_r     <= {CNT_W{1'b0}};
                        rdata_r   <= 32'h0000_0000;
                        fault_r   <= illegal_s;
                        mis_r     <= !illegal_s && misaligned_s;
                        if (!illegal_s && !misaligned_s) begin
                            we_r     <= mem_write_in;
                            baddr_r  <= {addr_in[31:2], 2'b00};
                            be_r     <= align_be_s;
                            bwdata_r <= align_wdata_s;
                        end
                    end
                end
                ST_REQ: begin
                    if (bus.bus_ack_in) begin
                        rdata_r <= we_r ? 32'h0000_0000 : align_rdata_s;
                    end else if (timeout_s) begin
                        fault_r <= 1'b1;
                    end else begin
                        cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign busy_out          = busy_r;
    assign done_out          = done_r;
    assign rdata_out         = rdata_r;
    assign misaligned_out    = mis_r;
    assign fault_out         = fault_r;
    assign bus.bus_req_out   = req_r;
    assign bus.bus_we_out    = we_r;
    assign bus.bus_addr_out  = baddr_r;
    assign bus.bus_be_out    = be_r;
    assign bus.bus_wdata_out = bwdata_r;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed, table-driven bench for load_store_unit with a 4-cycle bus timeout.
module tb_load_store_unit;
    import load_store_unit_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        valid_in;
    logic        mem_read_in;
    logic        mem_write_in;
    logic [3:0]  mem_width_in;
    logic        mem_zero_extend_in;
    logic [31:0] addr_in;
    logic [31:0] wdata_in;
    logic        busy_out;
    logic        done_out;
    logic [31:0] rdata_out;
    logic        misaligned_out;
    logic        fault_out;

    int n_cmp;
    int n_bad;

    load_store_unit_if bus_if ();

    load_store_unit #(.TIMEOUT_CYCLES(4)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .valid_in           (valid_in),
        .mem_read_in        (mem_read_in),
        .mem_write_in       (mem_write_in),
        .mem_width_in       (mem_width_in),
        .mem_zero_extend_in (mem_zero_extend_in),
        .addr_in            (addr_in),
        .wdata_in           (wdata_in),
        .busy_out           (busy_out),
        .done_out           (done_out),
        .rdata_out          (rdata_out),
        .misaligned_out     (misaligned_out),
        .fault_out          (fault_out),
        .bus                (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [3:0]  width;
        logic        zext;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] brdata;
        int          ack_delay;   // REQ cycle index carrying the ack; -1 = never
        logic        exp_mis;
        logic        exp_fault;
        logic [31:0] exp_rdata;
        logic [3:0]  exp_be;
        logic [31:0] exp_bwdata;
        int          exp_req;     // number of cycles with bus_req_out high
    } vec_t;

    vec_t vecs[15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " busy"},   32'(busy_out),              32'd0);
        chk({tag, " done"},   32'(done_out),              32'd0);
        chk({tag, " rdata"},  rdata_out,                  32'd0);
        chk({tag, " mis"},    32'(misaligned_out),        32'd0);
        chk({tag, " fault"},  32'(fault_out),             32'd0);
        chk({tag, " req"},    32'(bus_if.bus_req_out),    32'd0);
        chk({tag, " we"},     32'(bus_if.bus_we_out),     32'd0);
        chk({tag, " addr"},   bus_if.bus_addr_out,        32'd0);
        chk({tag, " be"},     32'(bus_if.bus_be_out),     32'd0);
        chk({tag, " wdata"},  bus_if.bus_wdata_out,       32'd0);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        bit    seen_done;
        bit    acked;
        int    req_cycles;
        string t;
        t          = $sformatf("v%0d", idx);
        seen_done  = 1'b0;
        acked      = 1'b0;
        req_cycles = 0;
        @(negedge clk);
        valid_in           = 1'b1;
        mem_read_in        = v.rd;
        mem_write_in       = v.wr;
        mem_width_in       = v.width;
        mem_zero_extend_in = v.zext;
        addr_in            = v.addr;
        wdata_in           = v.wdata;
        @(negedge clk);
        // Garbage on the inputs while busy must be ignored.
        valid_in     = 1'b1;
        mem_read_in  = 1'b1;
        mem_write_in = 1'b0;
        mem_width_in = MEM_WIDTH_WORD;
        addr_in      = 32'hFFFF_FFFC;
        wdata_in     = 32'h5555_5555;
        for (int c = 0; c < 20 && !seen_done; c++) begin
            if (done_out) begin
                seen_done = 1'b1;
                valid_in  = 1'b0;
                chk({t, " mis"},       32'(misaligned_out),     32'(v.exp_mis));
                chk({t, " fault"},     32'(fault_out),          32'(v.exp_fault));
                chk({t, " rdata"},     rdata_out,               v.exp_rdata);
                chk({t, " busy@done"}, 32'(busy_out),           32'd1);
                chk({t, " req@done"},  32'(bus_if.bus_req_out), 32'd0);
            end else begin
                if (acked) chk({t, " done after ack"}, 32'(done_out), 32'd1);
                chk({t, " busy"}, 32'(busy_out), 32'd1);
                if (bus_if.bus_req_out) begin
                    if (req_cycles == 0) begin
                        chk({t, " baddr"},  bus_if.bus_addr_out,     {v.addr[31:2], 2'b00});
                        chk({t, " be"},     32'(bus_if.bus_be_out),  32'(v.exp_be));
                        chk({t, " bwdata"}, bus_if.bus_wdata_out,    v.exp_bwdata);
                        chk({t, " we"},     32'(bus_if.bus_we_out),  32'(v.wr));
                    end
                    if (req_cycles == v.ack_delay) begin
                        bus_if.bus_ack_in   = 1'b1;
                        bus_if.bus_rdata_in = v.brdata;
                        acked               = 1'b1;
                    end
                    req_cycles++;
                end
            end
            @(negedge clk);
            bus_if.bus_ack_in   = 1'b0;
            bus_if.bus_rdata_in = 32'h0000_0000;
        end
        valid_in = 1'b0;
        chk({t, " done seen"},  32'(seen_done),  32'd1);
        chk({t, " req cycles"}, 32'(req_cycles), 32'(v.exp_req));
        // One cycle after DONE: pulse gone, back to IDLE, result held.
        chk({t, " done pulse"}, 32'(done_out),   32'd0);
        chk({t, " idle busy"},  32'(busy_out),   32'd0);
        chk({t, " rdata hold"}, rdata_out,       v.exp_rdata);
    endtask

    initial begin
        vec_t sw_vec;
        n_cmp = 0;
        n_bad = 0;
        rst_n              = 1'b0;
        valid_in           = 1'b0;
        mem_read_in        = 1'b0;
        mem_write_in       = 1'b0;
        mem_width_in       = MEM_WIDTH_WORD;
        mem_zero_extend_in = 1'b0;
        addr_in            = 32'h0;
        wdata_in           = 32'h0;
        bus_if.bus_ack_in   = 1'b0;
        bus_if.bus_rdata_in = 32'h0;

        //          rd    wr    width           zext  addr          wdata         brdata        ack  mis   flt   rdata         be       bwdata        req
        vecs[0]  = '{1'b0, 1'b1, MEM_WIDTH_BYTE, 1'b0, 32'h0000_1003, 32'h0000_00AB, 32'h0,         2, 1'b0, 1'b0, 32'h0,         4'b1000, 32'hABAB_ABAB, 3};
        vecs[1]  = '{1'b1, 1'b0, MEM_WIDTH_BYTE, 1'b0, 32'h0000_2001, 32'h0,         32'h0000_8000, 0, 1'b0, 1'b0, 32'hFFFF_FF80, 4'b0010, 32'h0,         1};
        vecs[2]  = '{1'b1, 1'b0, MEM_WIDTH_BYTE, 1'b1, 32'h0000_2001, 32'h0,         32'h0000_8000, 1, 1'b0, 1'b0, 32'h0000_0080, 4'b0010, 32'h0,         2};
        vecs[3]  = '{1'b1, 1'b0, MEM_WIDTH_HALF, 1'b0, 32'h0000_2002, 32'h0,         32'h1234_5678, 0, 1'b0, 1'b0, 32'h0000_1234, 4'b1100, 32'h0,         1};
        vecs[4]  = '{1'b1, 1'b0, MEM_WIDTH_HALF, 1'b0, 32'h0000_2000, 32'h0,         32'h0000_F00D, 1, 1'b0, 1'b0, 32'hFFFF_F00D, 4'b0011, 32'h0,         2};
        vecs[5]  = '{1'b1, 1'b0, MEM_WIDTH_HALF, 1'b1, 32'h0000_2002, 32'h0,         32'h8001_0000, 0, 1'b0, 1'b0, 32'h0000_8001, 4'b1100, 32'h0,         1};
        vecs[6]  = '{1'b1, 1'b0, MEM_WIDTH_BYTE, 1'b0, 32'h0000_2003, 32'h0,         32'h7F00_0000, 0, 1'b0, 1'b0, 32'h0000_007F, 4'b1000, 32'h0,         1};
        vecs[7]  = '{1'b1, 1'b0, MEM_WIDTH_WORD, 1'b0, 32'h0000_3000, 32'h0,         32'hCAFE_F00D, 1, 1'b0, 1'b0, 32'hCAFE_F00D, 4'b1111, 32'h0,         2};
        vecs[8]  = '{1'b1, 1'b0, MEM_WIDTH_WORD, 1'b0, 32'h0000_5000, 32'h0,         32'h0,        -1, 1'b0, 1'b1, 32'h0,         4'b1111, 32'h0,         4};
        vecs[9]  = '{1'b0, 1'b1, MEM_WIDTH_HALF, 1'b0, 32'h0000_1002, 32'h1234_BEEF, 32'h0,         0, 1'b0, 1'b0, 32'h0,         4'b1100, 32'hBEEF_BEEF, 1};
        vecs[10] = '{1'b1, 1'b0, MEM_WIDTH_WORD, 1'b0, 32'h0000_3002, 32'h0,         32'h0,         0, 1'b1, 1'b0, 32'h0,         4'b0000, 32'h0,         0};
        vecs[11] = '{1'b1, 1'b0, MEM_WIDTH_HALF, 1'b0, 32'h0000_2001, 32'h0,         32'h0,         0, 1'b1, 1'b0, 32'h0,         4'b0000, 32'h0,         0};
        vecs[12] = '{1'b1, 1'b1, MEM_WIDTH_WORD, 1'b0, 32'h0000_4000, 32'h0,         32'h0,         0, 1'b0, 1'b1, 32'h0,         4'b0000, 32'h0,         0};
        vecs[13] = '{1'b1, 1'b0, 4'b0011,        1'b0, 32'h0000_0010, 32'h0,         32'h0,         0, 1'b0, 1'b1, 32'h0,         4'b0000, 32'h0,         0};
        vecs[14] = '{1'b1, 1'b1, MEM_WIDTH_WORD, 1'b0, 32'h0000_4001, 32'h0,         32'h0,         0, 1'b0, 1'b1, 32'h0,         4'b0000, 32'h0,         0};

        repeat (2) @(negedge clk);
        chk_all_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 15; i++) run_vec(vecs[i], i);

        // Ack while idle must be ignored.
        @(negedge clk);
        bus_if.bus_ack_in   = 1'b1;
        bus_if.bus_rdata_in = 32'h1111_1111;
        @(negedge clk);
        bus_if.bus_ack_in   = 1'b0;
        chk("idle ack done", 32'(done_out), 32'd0);
        chk("idle ack busy", 32'(busy_out), 32'd0);
        @(negedge clk);
        chk("idle ack done2", 32'(done_out), 32'd0);

        // Reset in the middle of a pending request.
        valid_in     = 1'b1;
        mem_read_in  = 1'b1;
        mem_write_in = 1'b0;
        mem_width_in = MEM_WIDTH_WORD;
        addr_in      = 32'h0000_6000;
        @(negedge clk);
        valid_in = 1'b0;
        @(negedge clk);
        chk("pre-reset req", 32'(bus_if.bus_req_out), 32'd1);
        #2 rst_n = 1'b0;
        #1 chk_all_zero("async reset");
        @(negedge clk);
        chk("reset no done", 32'(done_out), 32'd0);
        rst_n = 1'b1;

        sw_vec = '{1'b0, 1'b1, MEM_WIDTH_WORD, 1'b0, 32'h0000_4000, 32'hDEAD_BEEF, 32'h0, 0,
                   1'b0, 1'b0, 32'h0, 4'b1111, 32'hDEAD_BEEF, 1};
        run_vec(sw_vec, 99);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
